// File: rtl/frame_strobe_sequencer.sv
// Frame strobe sequencer: turns a header + data word stream into
// FrameData/FrameStrobe writes for one tile column. Each data word is
// presented on FrameData for one setup cycle, strobed for one cycle, then
// held for one more cycle so the frame latches see clean setup and hold.
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 20,  // <= 255
  parameter int FrameBitsPerRow = 32   // >= 17
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       abort,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_DATA = 3'd1;
  localparam logic [2:0] SETUP     = 3'd2;
  localparam logic [2:0] STROBE    = 3'd3;
  localparam logic [2:0] HOLD      = 3'd4;

  // Widened to 9 bits so start+count cannot overflow before the range test.
  localparam logic [8:0] FrameLimit = 9'(MaxFramesPerCol);

  logic [2:0]                 state;
  logic [7:0]                 idx;       // frame line strobed next
  logic [7:0]                 rem;       // frames still to write in this burst
  logic                       accept;
  logic                       hdrMarker;
  logic [7:0]                 hdrStart;
  logic [7:0]                 hdrCount;
  logic [8:0]                 hdrEnd;
  logic                       hdrBad;
  logic [MaxFramesPerCol-1:0] strobeNext;

  // Words are taken only in IDLE/WAIT_DATA; abort and reset both block acceptance.
  assign s_ready = !reset && !abort && (state == IDLE || state == WAIT_DATA);
  assign accept  = s_valid && s_ready;

  assign hdrMarker = s_data[FrameBitsPerRow-1];
  assign hdrStart  = s_data[15:8];
  assign hdrCount  = s_data[7:0];
  assign hdrEnd    = {1'b0, hdrStart} + {1'b0, hdrCount};
  assign hdrBad    = !hdrMarker || (hdrCount == 8'd0) || (hdrEnd > FrameLimit);

  // busy stretches over the done cycle so it covers the whole burst inclusive.
  assign busy = (state != IDLE) || done;

  // Decode idx into the one-hot strobe pattern loaded on SETUP -> STROBE.
  always_comb begin
    strobeNext = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      if (idx == 8'(i)) strobeNext[i] = 1'b1;
    end
  end

  // Sequencer state, frame registers and the done/err pulses.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      rem         <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Strobe and pulses default low; only the SETUP branch raises the strobe.
      FrameStrobe <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      if (abort) begin
        // FrameData is deliberately kept; only the burst bookkeeping is dropped.
        state <= IDLE;
        idx   <= '0;
        rem   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (hdrBad) begin
                err <= 1'b1;
              end else begin
                idx   <= hdrStart;
                rem   <= hdrCount;
                state <= WAIT_DATA;
              end
            end
          end
          WAIT_DATA: begin
            // Raw data here: the marker bit carries no meaning.
            if (accept) begin
              FrameData <= s_data;
              state     <= SETUP;
            end
          end
          SETUP: begin
            FrameStrobe <= strobeNext;
            state       <= STROBE;
          end
          STROBE: begin
            state <= HOLD;
          end
          HOLD: begin
            // Header range check guarantees idx+1 stays within the column.
            rem <= rem - 8'd1;
            idx <= idx + 8'd1;
            if (rem == 8'd1) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= WAIT_DATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench for frame_strobe_sequencer. Each scenario fills a
// per-cycle stimulus table, plays it, then compares the recorded per-cycle
// outputs against hand-computed expectations.
module tb_frame_strobe_sequencer;

  logic        CLK;
  logic        reset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        abort;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int failures;

  // Per-cycle stimulus and recorded outputs; ctrl = {s_ready, busy, done, err}.
  logic        vV [64];
  logic [31:0] vD [64];
  logic        vA [64];
  logic        vR [64];
  logic [3:0]  rC [64];
  logic [19:0] rS [64];
  logic [31:0] rF [64];

  frame_strobe_sequencer #(
    .MaxFramesPerCol(20),
    .FrameBitsPerRow(32)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .abort      (abort),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case something stalls the stimulus process.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary, required summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] hdr(input logic [7:0] s, input logic [7:0] n);
    return {1'b1, 15'd0, s, n};
  endfunction

  task automatic clearStim();
    for (int i = 0; i < 64; i++) begin
      vV[i] = 1'b0; vD[i] = 32'd0; vA[i] = 1'b0; vR[i] = 1'b0;
    end
  endtask

  // Called just after a rising edge; drives cycle i, samples mid-cycle.
  task automatic runVec(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = vV[i]; s_data = vD[i]; abort = vA[i]; reset = vR[i];
      @(negedge CLK);
      rC[i] = {s_ready, busy, done, err};
      rS[i] = FrameStrobe;
      rF[i] = FrameData;
      @(posedge CLK);
      #1;
    end
    s_valid = 1'b0; s_data = 32'd0; abort = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    clearStim();
    vR[0] = 1'b1;
    runVec(2);
    checks++;
    if (rC[0] !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got %b exp %b", rC[0], 4'b0000); end
    checks++;
    if (rS[0] !== 20'h0) begin failures++; $display("FAIL reset_strobe got %h exp %h", rS[0], 20'h0); end
    checks++;
    if (rF[0] !== 32'h0) begin failures++; $display("FAIL reset_data got %h exp %h", rF[0], 32'h0); end
    checks++;
    if (rC[1] !== 4'b1000) begin failures++; $display("FAIL reset_release_ctrl got %b exp %b", rC[1], 4'b1000); end
  endtask

  task automatic test_two_frames();
    logic [3:0]  ec [11] = '{4'b1000, 4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b1100,
                             4'b0100, 4'b0100, 4'b0100, 4'b1110, 4'b1000};
    logic [19:0] es [11];
    logic [31:0] ed [11];
    for (int i = 0; i < 11; i++) begin
      es[i] = 20'h0;
      ed[i] = (i < 6) ? 32'hDEADBEEF : 32'h12345678;
    end
    es[3] = 20'h00008; es[7] = 20'h00010;
    clearStim();
    vV[0] = 1'b1; vD[0] = hdr(8'd3, 8'd2);
    vV[1] = 1'b1; vD[1] = 32'hDEADBEEF;
    vV[5] = 1'b1; vD[5] = 32'h12345678;
    runVec(11);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (rC[i] !== ec[i]) begin failures++; $display("FAIL two_frames_ctrl cyc%0d got %b exp %b", i, rC[i], ec[i]); end
      checks++;
      if (rS[i] !== es[i]) begin failures++; $display("FAIL two_frames_strobe cyc%0d got %h exp %h", i, rS[i], es[i]); end
      if (i >= 2) begin
        checks++;
        if (rF[i] !== ed[i]) begin failures++; $display("FAIL two_frames_data cyc%0d got %h exp %h", i, rF[i], ed[i]); end
      end
    end
  endtask

  task automatic test_last_frame();
    logic [3:0]  ec [10] = '{4'b1000, 4'b1100, 4'b0100, 4'b0100, 4'b0100,
                             4'b1110, 4'b1000, 4'b1001, 4'b1000, 4'b1000};
    logic [19:0] es [10];
    for (int i = 0; i < 10; i++) es[i] = 20'h0;
    es[3] = 20'h80000;
    clearStim();
    vV[0] = 1'b1; vD[0] = hdr(8'd19, 8'd1);
    vV[1] = 1'b1; vD[1] = 32'hA5A5A5A5;
    vV[6] = 1'b1; vD[6] = hdr(8'd19, 8'd2);
    runVec(10);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rC[i] !== ec[i]) begin failures++; $display("FAIL last_frame_ctrl cyc%0d got %b exp %b", i, rC[i], ec[i]); end
      checks++;
      if (rS[i] !== es[i]) begin failures++; $display("FAIL last_frame_strobe cyc%0d got %h exp %h", i, rS[i], es[i]); end
      if (i >= 2) begin
        checks++;
        if (rF[i] !== 32'hA5A5A5A5) begin failures++; $display("FAIL last_frame_data cyc%0d got %h exp %h", i, rF[i], 32'hA5A5A5A5); end
      end
    end
  endtask

  task automatic test_reject();
    logic [3:0] ec [5] = '{4'b1000, 4'b1001, 4'b1000, 4'b1001, 4'b1000};
    clearStim();
    vV[0] = 1'b1; vD[0] = hdr(8'd0, 8'd0);
    vV[2] = 1'b1; vD[2] = 32'h00001234;
    runVec(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rC[i] !== ec[i]) begin failures++; $display("FAIL reject_ctrl cyc%0d got %b exp %b", i, rC[i], ec[i]); end
      checks++;
      if (rS[i] !== 20'h0) begin failures++; $display("FAIL reject_strobe cyc%0d got %h exp %h", i, rS[i], 20'h0); end
    end
    checks++;
    if (rF[4] !== 32'hA5A5A5A5) begin failures++; $display("FAIL reject_data got %h exp %h", rF[4], 32'hA5A5A5A5); end
  endtask

  task automatic test_gaps();
    logic [3:0]  ec [21] = '{4'b1000, 4'b1100, 4'b0100, 4'b0100, 4'b0100,
                             4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
                             4'b0100, 4'b0100, 4'b0100, 4'b1100, 4'b1100,
                             4'b0100, 4'b0100, 4'b0100, 4'b1110, 4'b1000};
    logic [19:0] es [21];
    logic [31:0] ed [21];
    for (int i = 0; i < 21; i++) begin
      es[i] = 20'h0;
      ed[i] = (i <= 10) ? 32'h11111111 : (i <= 15) ? 32'hCAFEF00D : 32'h80000001;
    end
    es[3] = 20'h00001; es[12] = 20'h00002; es[17] = 20'h00004;
    clearStim();
    vV[0]  = 1'b1; vD[0]  = hdr(8'd0, 8'd3);
    vV[1]  = 1'b1; vD[1]  = 32'h11111111;
    vV[10] = 1'b1; vD[10] = 32'hCAFEF00D;
    vV[15] = 1'b1; vD[15] = 32'h80000001;
    runVec(21);
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (rC[i] !== ec[i]) begin failures++; $display("FAIL gaps_ctrl cyc%0d got %b exp %b", i, rC[i], ec[i]); end
      checks++;
      if (rS[i] !== es[i]) begin failures++; $display("FAIL gaps_strobe cyc%0d got %h exp %h", i, rS[i], es[i]); end
      if (i >= 2) begin
        checks++;
        if (rF[i] !== ed[i]) begin failures++; $display("FAIL gaps_data cyc%0d got %h exp %h", i, rF[i], ed[i]); end
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0]  ec [16] = '{4'b1000, 4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b1100,
                             4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1100,
                             4'b0100, 4'b0100, 4'b0100, 4'b1110, 4'b1000};
    logic [19:0] es [16];
    for (int i = 0; i < 16; i++) es[i] = 20'h0;
    es[3] = 20'h00010; es[7] = 20'h00020; es[12] = 20'h00004;
    clearStim();
    vV[0]  = 1'b1; vD[0]  = hdr(8'd4, 8'd4);
    vV[1]  = 1'b1; vD[1]  = 32'h0000AAAA;
    vV[5]  = 1'b1; vD[5]  = 32'h0000BBBB;
    vA[7]  = 1'b1;
    vA[8]  = 1'b1; vV[8]  = 1'b1; vD[8] = hdr(8'd7, 8'd1);
    vV[9]  = 1'b1; vD[9]  = hdr(8'd2, 8'd1);
    vV[10] = 1'b1; vD[10] = 32'h0000CCCC;
    runVec(16);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rC[i] !== ec[i]) begin failures++; $display("FAIL abort_ctrl cyc%0d got %b exp %b", i, rC[i], ec[i]); end
      checks++;
      if (rS[i] !== es[i]) begin failures++; $display("FAIL abort_strobe cyc%0d got %h exp %h", i, rS[i], es[i]); end
      if (i >= 6) begin
        checks++;
        if (rF[i] !== ((i <= 10) ? 32'h0000BBBB : 32'h0000CCCC)) begin
          failures++;
          $display("FAIL abort_data cyc%0d got %h exp %h", i, rF[i], (i <= 10) ? 32'h0000BBBB : 32'h0000CCCC);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] ec [7] = '{4'b1000, 4'b1100, 4'b0100, 4'b0000, 4'b1000, 4'b1001, 4'b1000};
    clearStim();
    vV[0] = 1'b1; vD[0] = hdr(8'd0, 8'd2);
    vV[1] = 1'b1; vD[1] = 32'h55AA55AA;
    vR[2] = 1'b1;
    vR[3] = 1'b1;
    vV[4] = 1'b1; vD[4] = 32'h00000042;
    runVec(7);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (rC[i] !== ec[i]) begin failures++; $display("FAIL rst_mid_ctrl cyc%0d got %b exp %b", i, rC[i], ec[i]); end
      checks++;
      if (rS[i] !== 20'h0) begin failures++; $display("FAIL rst_mid_strobe cyc%0d got %h exp %h", i, rS[i], 20'h0); end
      if (i >= 2) begin
        checks++;
        if (rF[i] !== ((i == 2) ? 32'h55AA55AA : 32'h0)) begin
          failures++;
          $display("FAIL rst_mid_data cyc%0d got %h exp %h", i, rF[i], (i == 2) ? 32'h55AA55AA : 32'h0);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    s_valid  = 1'b0;
    s_data   = 32'd0;
    abort    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_two_frames();
    test_last_frame();
    test_reject();
    test_gaps();
    test_abort();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
